// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the I-cache miss path, D-cache miss/write-back path,
// main memory and the arbiter. slave = arbiter view, master = environment view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              I_READ;
  logic [ADDR_W-1:0] I_ADDRESS;
  logic [DATA_W-1:0] I_READDATA;
  logic              I_BUSYWAIT;

  logic              D_READ;
  logic              D_WRITE;
  logic [ADDR_W-1:0] D_ADDRESS;
  logic [DATA_W-1:0] D_WRITEDATA;
  logic [DATA_W-1:0] D_READDATA;
  logic              D_BUSYWAIT;

  logic              M_READ;
  logic              M_WRITE;
  logic [ADDR_W-1:0] M_ADDRESS;
  logic [DATA_W-1:0] M_WRITEDATA;
  logic [DATA_W-1:0] M_READDATA;
  logic              M_BUSYWAIT;

  logic [1:0]        OWNER;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           M_READDATA, M_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA, OWNER
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           M_READDATA, M_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA, OWNER
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory block port between the I-cache
// miss path and the D-cache miss/write-back path, one transaction at a time.
// D side has fixed priority. Define ARB_STARVE_GUARD_EN to enable a
// starvation guard that forces an I grant after STARVE_LIMIT consecutive
// D grants made while I was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_req;
  logic done;
  logic guard;
  logic grant_i;

  assign d_req   = bus.D_READ | bus.D_WRITE;
  // Completion needs a live strobe; a busy memory with no strobe is ignored.
  assign done    = (m_read_q | m_write_q) & ~bus.M_BUSYWAIT;
  assign grant_i = bus.I_READ & (~d_req | guard);

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign guard = (starve_q == 3'(STARVE_LIMIT)) & bus.I_READ & d_req;

  // Count D grants that bypassed a waiting I request; any other grant clears.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_i)    starve_d = 3'd0;
      else if (d_req) starve_d = bus.I_READ ? starve_q + 3'd1 : 3'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) starve_q <= 3'd0;
    else       starve_q <= starve_d;
  end
`else
  logic unused_starve_limit;
  assign guard               = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  // Next state, grant latching, strobe control and read-data capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        owner_d = OWN_NONE;
        if (grant_i) begin
          state_d  = SERVE_I;
          owner_d  = OWN_I;
          m_addr_d = bus.I_ADDRESS;
          m_read_d = 1'b1;
        end else if (d_req) begin
          // Read and write together resolve to a write-back.
          state_d   = SERVE_D;
          owner_d   = OWN_D;
          m_addr_d  = bus.D_ADDRESS;
          m_wdata_d = bus.D_WRITEDATA;
          m_write_d = bus.D_WRITE;
          m_read_d  = ~bus.D_WRITE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (done) begin
          if (m_read_q) begin
            if (state_q == SERVE_I) i_rdata_d = bus.M_READDATA;
            else                    d_rdata_d = bus.M_READDATA;
          end
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // A requester stalls until the single RELEASE cycle of its own transaction.
  assign bus.I_BUSYWAIT  = bus.I_READ & ~((state_q == RELEASE) & (owner_q == OWN_I));
  assign bus.D_BUSYWAIT  = d_req & ~((state_q == RELEASE) & (owner_q == OWN_D));

  assign bus.I_READDATA  = i_rdata_q;
  assign bus.D_READDATA  = d_rdata_q;
  assign bus.M_READ      = m_read_q;
  assign bus.M_WRITE     = m_write_q;
  assign bus.M_ADDRESS   = m_addr_q;
  assign bus.M_WRITEDATA = m_wdata_q;
  assign bus.OWNER       = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory
// model and a grant scoreboard. Honours ARB_STARVE_GUARD_EN for the
// starvation scenario.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;

  typedef struct {
    logic [1:0]    own;
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {4'h0, a} ^ 32'hC0DE_0000;
    return {w, ~w, w + 32'd1, w ^ 32'h1234_5678};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input logic [1:0] o, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d);
    exp_t e;
    e.own = o; e.addr = a; e.wr = w; e.wdata = d;
    exp_q.push_back(e);
  endtask

  // Memory model: completes on the lat-th strobe cycle.
  int lat = 3;
  logic [7:0] mcnt;
  logic strobe;
  assign strobe = bus.M_READ | bus.M_WRITE;
  assign bus.M_BUSYWAIT = strobe && (int'(mcnt) < lat - 1);
  assign bus.M_READDATA = mdata(bus.M_ADDRESS);

  always @(posedge CLK or posedge RESET) begin
    if (RESET)                          mcnt <= 8'd0;
    else if (strobe && !bus.M_BUSYWAIT) mcnt <= 8'd0;
    else if (strobe)                    mcnt <= mcnt + 8'd1;
  end

  // Grant monitor: first strobe cycle of each transaction is checked
  // against the next scoreboard entry.
  logic prev_strobe = 1'b0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (strobe && !prev_strobe) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL grant_unexpected observed=owner%0d expected=none", bus.OWNER);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("grant_owner", bus.OWNER, mon_e.own);
        chk("grant_addr", bus.M_ADDRESS, mon_e.addr);
        chk("grant_write", bus.M_WRITE, mon_e.wr);
        chk("grant_read", bus.M_READ, !mon_e.wr);
        if (mon_e.wr) chk("grant_wdata", bus.M_WRITEDATA, mon_e.wdata);
      end
    end
    prev_strobe <= strobe;
  end

  // Wait for a side's BUSYWAIT to drop, counting sampled cycles; bounded.
  task automatic wait_low(input bit dside, input string tag, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((dside ? bus.D_BUSYWAIT : bus.I_BUSYWAIT) && n < 100);
    chk(tag, dside ? bus.D_BUSYWAIT : bus.I_BUSYWAIT, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n, rd_cycles, own1_cycles;
  logic ihi;
  logic [1:0] ord [6];
  logic [DW-1:0] wd2, wd4;

  initial begin
    bus.I_READ = 0; bus.I_ADDRESS = '0;
    bus.D_READ = 0; bus.D_WRITE = 0; bus.D_ADDRESS = '0; bus.D_WRITEDATA = '0;
    wd2 = {32'hDEAD_BEEF, 32'h0102_0304, 32'hA5A5_5A5A, 32'h0000_0020};
    wd4 = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};

    // Reset state
    @(negedge CLK);
    chk("rst_owner", bus.OWNER, OWN_NONE);
    chk("rst_mread", bus.M_READ, 1'b0);
    chk("rst_mwrite", bus.M_WRITE, 1'b0);
    chk("rst_maddr", bus.M_ADDRESS, '0);
    chk("rst_irdata", bus.I_READDATA, '0);
    chk("rst_drdata", bus.D_READDATA, '0);
    @(negedge CLK);
    RESET = 0;

    // 1: single I read, latency 3
    lat = 3;
    @(posedge CLK); #1;
    bus.I_READ = 1; bus.I_ADDRESS = 28'h0000010;
    push_exp(OWN_I, 28'h0000010, 1'b0, '0);
    n = 0; rd_cycles = 0; own1_cycles = 0;
    do begin
      @(negedge CLK);
      n++;
      if (n == 1) chk("t1_owner_first", bus.OWNER, OWN_NONE);
      if (bus.M_READ) rd_cycles++;
      if (bus.OWNER == OWN_I) own1_cycles++;
    end while (bus.I_BUSYWAIT && n < 100);
    chk("t1_busy_fall_cycle", n, lat + 2);
    chk("t1_mread_cycles", rd_cycles, 3);
    chk("t1_owner_cycles", own1_cycles, 4);
    chk("t1_irdata", bus.I_READDATA, mdata(28'h0000010));
    @(posedge CLK); #1;
    bus.I_READ = 0;
    @(negedge CLK);
    chk("t1_owner_idle", bus.OWNER, OWN_NONE);

    // 2: simultaneous D write and I read; D wins, I stalls throughout
    @(posedge CLK); #1;
    bus.D_WRITE = 1; bus.D_ADDRESS = 28'h0000020; bus.D_WRITEDATA = wd2;
    bus.I_READ = 1; bus.I_ADDRESS = 28'h0000030;
    push_exp(OWN_D, 28'h0000020, 1'b1, wd2);
    push_exp(OWN_I, 28'h0000030, 1'b0, '0);
    n = 0; ihi = 1'b1;
    do begin
      @(negedge CLK);
      n++;
      ihi &= bus.I_BUSYWAIT;
    end while (bus.D_BUSYWAIT && n < 100);
    chk("t2_d_done", bus.D_BUSYWAIT, 1'b0);
    chk("t2_i_stalled", ihi, 1'b1);
    @(posedge CLK); #1;
    bus.D_WRITE = 0;
    wait_low(1'b0, "t2_i_done", n);
    chk("t2_irdata", bus.I_READDATA, mdata(28'h0000030));
    chk("t2_drdata_kept", bus.D_READDATA, '0);
    @(posedge CLK); #1;
    bus.I_READ = 0;

    // 3: async reset two cycles into SERVE_D, I pending
    lat = 6;
    @(posedge CLK); #1;
    bus.D_READ = 1; bus.D_ADDRESS = 28'h0000040;
    bus.I_READ = 1; bus.I_ADDRESS = 28'h0000050;
    push_exp(OWN_D, 28'h0000040, 1'b0, '0);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);
    chk("t3_mread_pre", bus.M_READ, 1'b1);
    chk("t3_owner_pre", bus.OWNER, OWN_D);
    #1;
    RESET = 1; bus.D_READ = 0;
    #1;
    chk("t3_mread_rst", bus.M_READ, 1'b0);
    chk("t3_mwrite_rst", bus.M_WRITE, 1'b0);
    chk("t3_owner_rst", bus.OWNER, OWN_NONE);
    chk("t3_irdata_rst", bus.I_READDATA, '0);
    chk("t3_drdata_rst", bus.D_READDATA, '0);
    @(negedge CLK);
    RESET = 0;
    push_exp(OWN_I, 28'h0000050, 1'b0, '0);
    wait_low(1'b0, "t3_i_done", n);
    chk("t3_irdata", bus.I_READDATA, mdata(28'h0000050));
    @(posedge CLK); #1;
    bus.I_READ = 0;

    // 4: D_READ and D_WRITE together resolve to a write
    lat = 2;
    @(posedge CLK); #1;
    bus.D_READ = 1; bus.D_WRITE = 1; bus.D_ADDRESS = 28'h0000060; bus.D_WRITEDATA = wd4;
    push_exp(OWN_D, 28'h0000060, 1'b1, wd4);
    wait_low(1'b1, "t4_d_done", n);
    chk("t4_drdata_kept", bus.D_READDATA, '0);
    @(posedge CLK); #1;
    bus.D_READ = 0; bus.D_WRITE = 0;

    // 5: D_READ held through RELEASE -> back-to-back transactions
    @(posedge CLK); #1;
    bus.D_READ = 1; bus.D_ADDRESS = 28'h0000070;
    push_exp(OWN_D, 28'h0000070, 1'b0, '0);
    push_exp(OWN_D, 28'h0000070, 1'b0, '0);
    wait_low(1'b1, "t5_first_done", n);
    chk("t5_drdata", bus.D_READDATA, mdata(28'h0000070));
    @(negedge CLK);
    chk("t5_gap_one_cycle", bus.D_BUSYWAIT, 1'b1);
    chk("t5_gap_owner", bus.OWNER, OWN_NONE);
    wait_low(1'b1, "t5_second_done", n);
    @(posedge CLK); #1;
    bus.D_READ = 0;
    @(negedge CLK);
    chk("t5_idle_busy", bus.D_BUSYWAIT, 1'b0);

    // 6: I held while D requests back-to-back
    lat = 1;
`ifdef ARB_STARVE_GUARD_EN
    ord = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_I, OWN_D};
`else
    ord = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_D, OWN_D};
`endif
    for (int k = 0; k < 6; k++)
      push_exp(ord[k], (ord[k] == OWN_I) ? 28'h0000080 : 28'h0000090, 1'b0, '0);
    @(posedge CLK); #1;
    bus.I_READ = 1; bus.I_ADDRESS = 28'h0000080;
    bus.D_READ = 1; bus.D_ADDRESS = 28'h0000090;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (!((bus.I_READ && !bus.I_BUSYWAIT) || (bus.D_READ && !bus.D_BUSYWAIT)) && n < 100);
      chk("t6_release_owner", bus.OWNER, ord[k]);
      if (bus.OWNER == OWN_I) begin
        @(posedge CLK); #1;
        bus.I_READ = 0;
      end
    end
`ifndef ARB_STARVE_GUARD_EN
    chk("t6_i_starved", bus.I_BUSYWAIT, 1'b1);
`endif
    @(posedge CLK); #1;
    bus.I_READ = 0; bus.D_READ = 0;
    @(negedge CLK); @(negedge CLK);
    chk("sb_empty", exp_q.size(), 0);
    chk("end_owner", bus.OWNER, OWN_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
